// File: rtl/multi_byte_instruction_register_if.sv
// Control and status bundle between the control sequencer and the
// multi-byte instruction register. The shared tristate bus is kept as a
// plain inout on the register itself so it resolves at the bus owner.
interface multi_byte_instruction_register_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_BYTES = 3
);
    logic                           read_from_bus;
    logic                           write_to_bus;
    logic                           next_instr;
    logic [WIDTH-1:0]               value;
    logic [WIDTH*(MAX_BYTES-1)-1:0] operand;
    logic [1:0]                     instr_len;
    logic [1:0]                     byte_idx;
    logic                           complete;
    logic                           overrun;
    logic                           bus_conflict;

    modport master (
        output read_from_bus, write_to_bus, next_instr,
        input  value, operand, instr_len, byte_idx, complete, overrun, bus_conflict
    );

    modport slave (
        input  read_from_bus, write_to_bus, next_instr,
        output value, operand, instr_len, byte_idx, complete, overrun, bus_conflict
    );
endinterface

// File: rtl/multi_byte_instruction_register.sv
// Assembles 1..MAX_BYTES-word instructions from the shared bus. Word 0 is
// the opcode word and carries a 2-bit extra-word count at LEN_LSB; the
// remaining words are packed into operand, word k at [k*WIDTH-1 -: WIDTH].
//
// state        | meaning
// FETCH_FIRST  | waiting for the opcode word
// FETCH_EXTRA  | collecting operand words, byte_idx = next word index
// COMPLETE     | instruction assembled, further captures flag overrun
module multi_byte_instruction_register #(
    parameter int               WIDTH       = 8,
    parameter int               MAX_BYTES   = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = 8'h0F,
    parameter int               LEN_LSB     = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    inout  wire  [WIDTH-1:0]                bus,
    multi_byte_instruction_register_if.slave ifc
);
    localparam int         OPW       = WIDTH * (MAX_BYTES - 1);
    localparam logic [1:0] MAX_EXTRA = 2'(MAX_BYTES - 1);

    typedef enum logic [1:0] {
        FETCH_FIRST,
        FETCH_EXTRA,
        COMPLETE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] value_q;
    logic [OPW-1:0]   operand_q;
    logic [1:0]       instr_len_q;
    logic [1:0]       byte_idx_q;
    logic             complete_q;
    logic             overrun_q;
    logic             bus_conflict_q;

    logic             cap;
    logic [1:0]       len_raw;
    logic [1:0]       len_sat;
    logic [WIDTH-1:0] drive_word;

    // Driving always wins over capturing, so a conflicting cycle never
    // loads our own driven value back into the register.
    assign cap     = ifc.read_from_bus & ~ifc.write_to_bus;
    assign len_raw = bus[LEN_LSB+1:LEN_LSB];
    assign len_sat = (len_raw > MAX_EXTRA) ? MAX_EXTRA : len_raw;

    // Read-back word: first operand for multi-word instructions, otherwise
    // the address nibble held in the low half of the opcode word.
    assign drive_word = (instr_len_q >= 2'd1) ? operand_q[WIDTH-1:0]
                                              : {{(WIDTH/2){1'b0}}, value_q[WIDTH/2-1:0]};
    assign bus        = ifc.write_to_bus ? drive_word : {WIDTH{1'bz}};

    // Instruction assembly state machine; later assignments in the block
    // override the next_instr clear so a same-cycle word 0 takes effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FETCH_FIRST;
            value_q        <= RESET_VALUE;
            operand_q      <= '0;
            instr_len_q    <= 2'd0;
            byte_idx_q     <= 2'd0;
            complete_q     <= 1'b0;
            overrun_q      <= 1'b0;
            bus_conflict_q <= 1'b0;
        end else begin
            bus_conflict_q <= ifc.read_from_bus & ifc.write_to_bus;
            if (ifc.next_instr) begin
                complete_q <= 1'b0;
                overrun_q  <= 1'b0;
                byte_idx_q <= 2'd0;
                state      <= FETCH_FIRST;
            end
            if (cap && (ifc.next_instr || state == FETCH_FIRST)) begin
                value_q     <= bus;
                operand_q   <= '0;
                instr_len_q <= len_sat;
                if (len_sat == 2'd0) begin
                    state      <= COMPLETE;
                    complete_q <= 1'b1;
                end else begin
                    byte_idx_q <= 2'd1;
                    state      <= FETCH_EXTRA;
                end
            end else if (cap && state == FETCH_EXTRA) begin
                for (int k = 1; k < MAX_BYTES; k++) begin
                    if (byte_idx_q == 2'(k)) begin
                        operand_q[k*WIDTH-1 -: WIDTH] <= bus;
                    end
                end
                if (byte_idx_q == instr_len_q) begin
                    state      <= COMPLETE;
                    complete_q <= 1'b1;
                end else begin
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end else if (cap && state == COMPLETE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign ifc.value        = value_q;
    assign ifc.operand      = operand_q;
    assign ifc.instr_len    = instr_len_q;
    assign ifc.byte_idx     = byte_idx_q;
    assign ifc.complete     = complete_q;
    assign ifc.overrun      = overrun_q;
    assign ifc.bus_conflict = bus_conflict_q;
endmodule
